// File: rtl/uevc_pkg.sv
// Shared definitions for the microprogram sequencer: mode and condition codes,
// sequencer states, flag positions and the branch-condition evaluator.
package uevc_pkg;

    localparam int UA_W = 10;

    localparam logic [2:0] UM_NEXT   = 3'b000;
    localparam logic [2:0] UM_JUMP   = 3'b001;
    localparam logic [2:0] UM_BRANCH = 3'b010;
    localparam logic [2:0] UM_DECODE = 3'b011;
    localparam logic [2:0] UM_CALL   = 3'b100;
    localparam logic [2:0] UM_RETURN = 3'b101;

    localparam logic [3:0] CC_ALWAYS = 4'd0;
    localparam logic [3:0] CC_N      = 4'd1;
    localparam logic [3:0] CC_Z      = 4'd2;
    localparam logic [3:0] CC_V      = 4'd3;
    localparam logic [3:0] CC_C      = 4'd4;
    localparam logic [3:0] CC_NN     = 4'd5;
    localparam logic [3:0] CC_NZ     = 4'd6;
    localparam logic [3:0] CC_NV     = 4'd7;
    localparam logic [3:0] CC_NC     = 4'd8;
    localparam logic [3:0] CC_LT     = 4'd9;
    localparam logic [3:0] CC_LE     = 4'd10;

    // FLAGS_IN is packed as {N,Z,V,C}
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    function automatic logic eval_cond(input logic [3:0] sel, input logic [3:0] flags);
        logic n, z, v, c, res;
        n = flags[FLAG_N];
        z = flags[FLAG_Z];
        v = flags[FLAG_V];
        c = flags[FLAG_C];
        case (sel)
            CC_ALWAYS: res = 1'b1;
            CC_N:      res = n;
            CC_Z:      res = z;
            CC_V:      res = v;
            CC_C:      res = c;
            CC_NN:     res = !n;
            CC_NZ:     res = !z;
            CC_NV:     res = !v;
            CC_NC:     res = !c;
            CC_LT:     res = n ^ v;
            CC_LE:     res = z | (n ^ v);
            default:   res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/micro_sequencer_if.sv
// MIR/datapath-facing bundle of the sequencer: microinstruction fields and
// flags in, control-store address and status out.
interface micro_sequencer_if;
    import uevc_pkg::*;

    logic [6:0]      Type_IN;
    logic [UA_W-1:0] DAdd_IN;
    logic            MR_IN;
    logic            MW_IN;
    logic [3:0]      FLAGS_IN;
    logic [7:0]      OP_IN;
    logic            MEM_RDY;
    logic [UA_W-1:0] CSAI;
    logic [UA_W-1:0] UPC;
    logic            MEM_REQ;
    logic            STALL;
    logic            ERR;

    modport master (
        output Type_IN, DAdd_IN, MR_IN, MW_IN, FLAGS_IN, OP_IN, MEM_RDY,
        input  CSAI, UPC, MEM_REQ, STALL, ERR
    );

    modport slave (
        input  Type_IN, DAdd_IN, MR_IN, MW_IN, FLAGS_IN, OP_IN, MEM_RDY,
        output CSAI, UPC, MEM_REQ, STALL, ERR
    );

endinterface

// File: rtl/micro_stack.sv
// Micro-return LIFO: drops pushes when full, reads back zero when empty.
module micro_stack
    import uevc_pkg::*;
#(
    parameter int STACK_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            pop,
    input  logic [UA_W-1:0] push_data,
    output logic [UA_W-1:0] top,
    output logic            full,
    output logic            empty
);

    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = $clog2(STACK_DEPTH);

    logic [UA_W-1:0]  mem [STACK_DEPTH];
    logic [SP_W-1:0]  sp;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] top_idx;

    assign full    = (sp == SP_W'(STACK_DEPTH));
    assign empty   = (sp == '0);
    assign wr_idx  = IDX_W'(sp);
    assign top_idx = IDX_W'(sp - 1'b1);
    assign top     = empty ? '0 : mem[top_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + 1'b1;
        end else if (pop && !empty) begin
            sp <= sp - 1'b1;
        end
    end

    // Entries are only meaningful below sp, so storage needs no reset.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/micro_sequencer.sv
// Next-address controller: selects CSAI from the MIR mode/condition, holds the
// sequence during memory cycles, and traps on stack misuse or memory timeout.
module micro_sequencer
    import uevc_pkg::*;
#(
    parameter int              STACK_DEPTH = 4,
    parameter int              WAIT_LIMIT  = 15,
    parameter logic [UA_W-1:0] FAULT_VEC   = 10'h3F0
) (
    input logic               CLK,
    input logic               RST_N,
    micro_sequencer_if.slave  bus
);

    localparam int CNT_W = $clog2(WAIT_LIMIT + 1);

    state_t          state, next_state;
    logic [UA_W-1:0] upc;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_next;
    logic            err, err_set;

    logic [UA_W-1:0] csai;
    logic [UA_W-1:0] upc_inc;
    logic [UA_W-1:0] target;
    logic [2:0]      mode;
    logic            mem_req, stall;
    logic            push, pop, want_push, want_pop;
    logic [UA_W-1:0] stk_top;
    logic            stk_full, stk_empty;

    micro_stack #(.STACK_DEPTH(STACK_DEPTH)) u_stack (
        .clk       (CLK),
        .rst_n     (RST_N),
        .push      (push),
        .pop       (pop),
        .push_data (upc_inc),
        .top       (stk_top),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    assign mode    = bus.Type_IN[6:4];
    assign upc_inc = upc + UA_W'(1);

    // Target address if this cycle advances; 110/111 fall through to NEXT.
    always_comb begin
        target    = upc_inc;
        want_push = 1'b0;
        want_pop  = 1'b0;
        case (mode)
            UM_JUMP:   target = bus.DAdd_IN;
            UM_BRANCH: target = eval_cond(bus.Type_IN[3:0], bus.FLAGS_IN) ? bus.DAdd_IN : upc_inc;
            UM_DECODE: target = {1'b1, bus.OP_IN, 1'b0};
            UM_CALL: begin
                target    = bus.DAdd_IN;
                want_push = 1'b1;
            end
            UM_RETURN: begin
                target   = stk_top;
                want_pop = 1'b1;
            end
            default:   target = upc_inc;
        endcase
    end

    always_comb begin
        next_state    = state;
        csai          = '0;
        mem_req       = 1'b0;
        stall         = 1'b0;
        push          = 1'b0;
        pop           = 1'b0;
        err_set       = 1'b0;
        wait_cnt_next = wait_cnt;
        case (state)
            ST_RUN, ST_WAIT: begin
                mem_req = bus.MR_IN | bus.MW_IN;
                if (mem_req && !bus.MEM_RDY) begin
                    if (wait_cnt == CNT_W'(WAIT_LIMIT)) begin
                        csai          = FAULT_VEC;
                        err_set       = 1'b1;
                        wait_cnt_next = '0;
                        next_state    = ST_RUN;
                    end else begin
                        csai          = upc;
                        stall         = 1'b1;
                        wait_cnt_next = CNT_W'(wait_cnt + 1'b1);
                        next_state    = ST_WAIT;
                    end
                end else begin
                    csai          = target;
                    push          = want_push;
                    pop           = want_pop;
                    err_set       = (want_push && stk_full) || (want_pop && stk_empty);
                    wait_cnt_next = '0;
                    next_state    = ST_RUN;
                end
            end
            default: begin
                csai          = '0;
                wait_cnt_next = '0;
                next_state    = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= ST_BOOT;
            upc      <= '0;
            wait_cnt <= '0;
            err      <= 1'b0;
        end else begin
            state    <= next_state;
            upc      <= csai;
            wait_cnt <= wait_cnt_next;
            err      <= err | err_set;
        end
    end

    assign bus.CSAI    = csai;
    assign bus.UPC     = upc;
    assign bus.MEM_REQ = mem_req;
    assign bus.STALL   = stall;
    assign bus.ERR     = err;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: address-selection vectors from a table,
// then hand-written call/return, memory-wait, timeout and reset sequences.
module tb_micro_sequencer;
    import uevc_pkg::*;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    int   tests = 0;
    int   fails = 0;

    micro_sequencer_if bus();

    micro_sequencer #(
        .STACK_DEPTH (4),
        .WAIT_LIMIT  (15),
        .FAULT_VEC   (10'h3F0)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [2:0] mode;
        logic [3:0] cond;
        logic [9:0] upc;
        logic [9:0] dadd;
        logic [3:0] flags;
        logic [7:0] op;
        logic [9:0] exp;
    } vec_t;

    vec_t vecs [12];
    logic [9:0] call_tgt [4];
    logic [9:0] ret_exp  [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_mir(input logic [2:0] mode, input logic [3:0] cond, input logic [9:0] dadd);
        bus.Type_IN = {mode, cond};
        bus.DAdd_IN = dadd;
    endtask

    task automatic goto(input logic [9:0] addr);
        bus.MR_IN = 1'b0;
        bus.MW_IN = 1'b0;
        set_mir(UM_JUMP, 4'd0, addr);
        tick();
    endtask

    task automatic do_reset();
        RST_N       = 1'b0;
        bus.MR_IN   = 1'b0;
        bus.MW_IN   = 1'b0;
        bus.MEM_RDY = 1'b0;
        #2;
        RST_N = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //          mode       cond  upc     dadd    flags    op     exp
        vecs[0]  = '{UM_BRANCH, 4'd2,  10'h010, 10'h080, 4'b0100, 8'h00, 10'h080};
        vecs[1]  = '{UM_BRANCH, 4'd2,  10'h010, 10'h080, 4'b1011, 8'h00, 10'h011};
        vecs[2]  = '{UM_BRANCH, 4'd12, 10'h010, 10'h080, 4'b1111, 8'h00, 10'h011};
        vecs[3]  = '{UM_DECODE, 4'd0,  10'h123, 10'h000, 4'b0000, 8'h5A, 10'h2B4};
        vecs[4]  = '{UM_NEXT,   4'd0,  10'h3FF, 10'h000, 4'b0000, 8'h00, 10'h000};
        vecs[5]  = '{UM_JUMP,   4'd0,  10'h005, 10'h2AA, 4'b0000, 8'h00, 10'h2AA};
        vecs[6]  = '{UM_BRANCH, 4'd9,  10'h050, 10'h1C0, 4'b1000, 8'h00, 10'h1C0};
        vecs[7]  = '{UM_BRANCH, 4'd10, 10'h050, 10'h1C0, 4'b1010, 8'h00, 10'h051};
        vecs[8]  = '{UM_BRANCH, 4'd8,  10'h060, 10'h1C0, 4'b0001, 8'h00, 10'h061};
        vecs[9]  = '{3'b110,    4'd0,  10'h070, 10'h1C0, 4'b0000, 8'h00, 10'h071};
        vecs[10] = '{UM_BRANCH, 4'd0,  10'h070, 10'h0F0, 4'b0000, 8'h00, 10'h0F0};
        vecs[11] = '{UM_DECODE, 4'd0,  10'h070, 10'h000, 4'b0000, 8'hFF, 10'h3FE};
        call_tgt = '{10'h200, 10'h300, 10'h040, 10'h060};
        ret_exp  = '{10'h041, 10'h301, 10'h201, 10'h101};

        bus.Type_IN  = {UM_JUMP, 4'd0};
        bus.DAdd_IN  = 10'h155;
        bus.MR_IN    = 1'b1;
        bus.MW_IN    = 1'b0;
        bus.FLAGS_IN = 4'b0000;
        bus.OP_IN    = 8'h00;
        bus.MEM_RDY  = 1'b0;

        // Reset and boot
        #1;
        chk("rst_csai", 32'(bus.CSAI), 0);
        chk("rst_upc", 32'(bus.UPC), 0);
        chk("rst_err", 32'(bus.ERR), 0);
        chk("rst_memreq", 32'(bus.MEM_REQ), 0);
        chk("rst_stall", 32'(bus.STALL), 0);
        tick();
        RST_N = 1'b1;
        #1;
        chk("boot_csai", 32'(bus.CSAI), 0);
        chk("boot_memreq", 32'(bus.MEM_REQ), 0);
        bus.MR_IN = 1'b0;
        tick();
        chk("boot_upc", 32'(bus.UPC), 0);
        chk("run_first_csai", 32'(bus.CSAI), 32'h155);

        // Address-selection vectors
        for (int i = 0; i < 12; i++) begin
            goto(vecs[i].upc);
            set_mir(vecs[i].mode, vecs[i].cond, vecs[i].dadd);
            bus.FLAGS_IN = vecs[i].flags;
            bus.OP_IN    = vecs[i].op;
            #1;
            chk($sformatf("vec%0d_csai", i), 32'(bus.CSAI), 32'(vecs[i].exp));
        end
        tick();
        chk("vec_last_upc", 32'(bus.UPC), 32'h3FE);

        // Nested calls, overflow, returns
        do_reset();
        goto(10'h100);
        for (int i = 0; i < 4; i++) begin
            set_mir(UM_CALL, 4'd0, call_tgt[i]);
            #1;
            chk($sformatf("call%0d_csai", i), 32'(bus.CSAI), 32'(call_tgt[i]));
            tick();
        end
        chk("call4_err", 32'(bus.ERR), 0);
        set_mir(UM_CALL, 4'd0, 10'h070);
        #1;
        chk("ovf_csai", 32'(bus.CSAI), 32'h070);
        tick();
        chk("ovf_upc", 32'(bus.UPC), 32'h070);
        chk("ovf_err", 32'(bus.ERR), 1);
        for (int i = 0; i < 4; i++) begin
            set_mir(UM_RETURN, 4'd0, 10'h000);
            #1;
            chk($sformatf("ret%0d_csai", i), 32'(bus.CSAI), 32'(ret_exp[i]));
            tick();
        end

        // Underflow
        do_reset();
        chk("unf_err_before", 32'(bus.ERR), 0);
        set_mir(UM_RETURN, 4'd0, 10'h123);
        #1;
        chk("unf_csai", 32'(bus.CSAI), 0);
        tick();
        chk("unf_err", 32'(bus.ERR), 1);

        // Memory wait of three cycles
        do_reset();
        goto(10'h020);
        set_mir(UM_CALL, 4'd0, 10'h180);
        bus.MR_IN   = 1'b1;
        bus.MEM_RDY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("wait%0d_stall", i), 32'(bus.STALL), 1);
            chk($sformatf("wait%0d_csai", i), 32'(bus.CSAI), 32'h020);
            chk($sformatf("wait%0d_memreq", i), 32'(bus.MEM_REQ), 1);
            tick();
        end
        chk("wait_upc_held", 32'(bus.UPC), 32'h020);
        bus.MEM_RDY = 1'b1;
        #1;
        chk("rdy_stall", 32'(bus.STALL), 0);
        chk("rdy_csai", 32'(bus.CSAI), 32'h180);
        tick();
        chk("rdy_upc", 32'(bus.UPC), 32'h180);
        // Exactly one entry should have been pushed across the stalled CALL
        bus.MR_IN = 1'b0;
        set_mir(UM_RETURN, 4'd0, 10'h000);
        #1;
        chk("wait_ret_csai", 32'(bus.CSAI), 32'h021);
        tick();
        chk("wait_ret_err", 32'(bus.ERR), 0);
        set_mir(UM_RETURN, 4'd0, 10'h000);
        tick();
        chk("wait_ret2_err", 32'(bus.ERR), 1);

        // Ready in the first cycle, and a write request
        do_reset();
        goto(10'h021);
        set_mir(UM_NEXT, 4'd0, 10'h000);
        bus.MR_IN   = 1'b1;
        bus.MEM_RDY = 1'b1;
        #1;
        chk("rdy1_stall", 32'(bus.STALL), 0);
        chk("rdy1_csai", 32'(bus.CSAI), 32'h022);
        bus.MR_IN   = 1'b0;
        bus.MW_IN   = 1'b1;
        bus.MEM_RDY = 1'b0;
        #1;
        chk("mw_stall", 32'(bus.STALL), 1);
        chk("mw_csai", 32'(bus.CSAI), 32'h021);

        // Timeout trap
        do_reset();
        goto(10'h030);
        set_mir(UM_NEXT, 4'd0, 10'h000);
        bus.MR_IN   = 1'b1;
        bus.MEM_RDY = 1'b0;
        begin
            int n_stall = 0;
            for (int i = 0; i < 15; i++) begin
                #1;
                if (bus.STALL === 1'b1) n_stall++;
                tick();
            end
            chk("to_stall_cycles", 32'(n_stall), 15);
        end
        #1;
        chk("to_csai", 32'(bus.CSAI), 32'h3F0);
        chk("to_stall", 32'(bus.STALL), 0);
        chk("to_err_before", 32'(bus.ERR), 0);
        tick();
        chk("to_upc", 32'(bus.UPC), 32'h3F0);
        chk("to_err", 32'(bus.ERR), 1);
        #1;
        chk("to_restall", 32'(bus.STALL), 1);

        // Ready arriving on the timeout cycle wins
        do_reset();
        goto(10'h030);
        set_mir(UM_NEXT, 4'd0, 10'h000);
        bus.MR_IN   = 1'b1;
        bus.MEM_RDY = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        bus.MEM_RDY = 1'b1;
        #1;
        chk("to_rdy_csai", 32'(bus.CSAI), 32'h031);
        tick();
        chk("to_rdy_upc", 32'(bus.UPC), 32'h031);
        chk("to_rdy_err", 32'(bus.ERR), 0);

        // Asynchronous reset in the middle of a wait
        do_reset();
        set_mir(UM_RETURN, 4'd0, 10'h000);
        tick();
        goto(10'h040);
        set_mir(UM_NEXT, 4'd0, 10'h000);
        bus.MR_IN   = 1'b1;
        bus.MEM_RDY = 1'b0;
        tick();
        tick();
        chk("mid_pre_stall", 32'(bus.STALL), 1);
        chk("mid_pre_err", 32'(bus.ERR), 1);
        chk("mid_pre_upc", 32'(bus.UPC), 32'h040);
        RST_N = 1'b0;
        #1;
        chk("mid_csai", 32'(bus.CSAI), 0);
        chk("mid_memreq", 32'(bus.MEM_REQ), 0);
        chk("mid_stall", 32'(bus.STALL), 0);
        chk("mid_upc", 32'(bus.UPC), 0);
        chk("mid_err", 32'(bus.ERR), 0);
        RST_N = 1'b1;
        bus.MR_IN = 1'b0;
        tick();
        chk("mid_boot_upc", 32'(bus.UPC), 0);
        #1;
        chk("mid_run_csai", 32'(bus.CSAI), 32'h001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/micro_sequencer.md
# micro_sequencer

Next-address controller for the microprogrammed control unit. It holds the microprogram counter, decodes the Type and DAdd fields of the microinstruction currently held in the MIR, and evaluates the datapath flags. It drives the control-store address (CSAI) that the MIR loads on every clock edge. It also stalls the sequence on MR/MW memory cycles, provides a small call/return stack, and traps on memory timeout.

## Interface
- STACK_DEPTH, 4: micro-return stack entries (2..8)
- WAIT_LIMIT, 15: max stall cycles before timeout trap
- FAULT_VEC, 10'h3F0: trap microaddress
- CLK in 1: single system clock, rising edge
- RST_N in 1: asynchronous, active-low reset
- Type_IN in 7: MIR Type field; [6:4] mode, [3:0] condition select
- DAdd_IN in 10: MIR target microaddress
- MR_IN, MW_IN in 1 each: MIR memory read/write request
- FLAGS_IN in 4: {N,Z,V,C} from datapath status register
- OP_IN in 8: macro-instruction opcode from IR
- MEM_RDY in 1: memory completion strobe
- CSAI out 10: control-store address; ROM is read asynchronously, and MIR loads ROM[CSAI] on every edge
- UPC out 10: address of the word currently in MIR
- MEM_REQ out 1: memory cycle in progress
- STALL out 1: current microinstruction is being held; datapath suppresses SelC write-back
- ERR out 1: sticky fault (overflow, underflow, timeout)

## Operation
- States: BOOT, RUN, WAIT.
- BOOT: CSAI=0. On the next edge: UPC<=0, go to RUN.
- Modes (Type_IN[6:4]):
  - 000 NEXT: UPC+1
  - 001 JUMP: DAdd
  - 010 BRANCH: DAdd if cond, else UPC+1
  - 011 DECODE: {1'b1, OP_IN, 1'b0}
  - 100 CALL: push UPC+1, then DAdd
  - 101 RETURN: pop
  - 110/111: treated as NEXT
- Condition select (Type_IN[3:0]):
  - 0 always; 1 N; 2 Z; 3 V; 4 C
  - 5 !N; 6 !Z; 7 !V; 8 !C
  - 9 N^V; 10 Z|(N^V)
  - 11..15: false
- Arithmetic is 10-bit modulo: 10'h3FF+1 wraps to 0.
- Memory handshake:
  - MEM_REQ=(MR_IN|MW_IN) in RUN/WAIT.
  - If MEM_REQ and !MEM_RDY: CSAI=UPC, STALL=1, go to or stay in WAIT, wait counter +1.
  - When MEM_RDY=1 (this can happen in the first cycle): advance normally, STALL=0, counter cleared, return to RUN.
- Push/pop happen only on an advancing cycle, never while stalled.
- Overflow: a CALL with the stack full still jumps, but the push is dropped and ERR<=1.
- Underflow: a RETURN with the stack empty gives CSAI=0 and ERR<=1.
- Timeout: counter==WAIT_LIMIT with MEM_RDY still 0 gives CSAI=FAULT_VEC, STALL=0, ERR<=1, counter cleared, RUN. The stack is preserved.

## Timing
- CSAI is combinational from state, UPC, MIR fields, FLAGS_IN, OP_IN, MEM_RDY, and stack top.
- UPC<=CSAI every edge; MIR therefore always holds ROM[UPC].
- Next-address latency is zero cycles: the branch target is executing one edge after its evaluation.
- FLAGS_IN is sampled in the same cycle as the BRANCH.
- Reset (asynchronous, any time, including during WAIT or a push) sets state=BOOT, UPC=0, stack pointer=0, wait counter=0, ERR=0. During reset: CSAI=0, MEM_REQ=0, STALL=0.
- MEM_RDY is ignored when MEM_REQ=0.
- A MEM_RDY that arrives on the timeout cycle wins: normal advance, no trap.

## Structure
- Shared package uevc_pkg:
  - mode constants: UM_NEXT, UM_JUMP, UM_BRANCH, UM_DECODE, UM_CALL, UM_RETURN
  - condition codes
  - state enum
  - microaddress width 10
  - flag bit indices
- Sub-module micro_stack: LIFO of STACK_DEPTH × 10 bits, with push/pop/top/full/empty. It ignores a push when full and returns 0 on an empty pop.

## Test plan
- Reset release: RST_N 0→1. Required: CSAI=0 in BOOT, UPC=0 after 1 edge, ERR=0.
- BRANCH: UPC=0x010, Type=010_0010, DAdd=0x080.
  - Z=1: CSAI=0x080.
  - Z=0: CSAI=0x011.
  - cond=12: CSAI=0x011.
- DECODE/NEXT wrap:
  - OP_IN=0x5A gives CSAI=0x2B4.
  - NEXT at UPC=0x3FF gives CSAI=0x000.
- CALL/RETURN nesting: 4 CALLs from 0x100/0x200/0x300/0x040 then 4 RETURNs.
  - Required return order: 0x041, 0x301, 0x201, 0x101.
  - A 5th CALL sets ERR=1 and still jumps.
  - RETURN on empty gives CSAI=0 and ERR=1.
- Memory wait: MR_IN=1, MEM_RDY low for 3 cycles.
  - Required: STALL=1 and CSAI=UPC for 3 cycles, then advance on the RDY cycle.
  - MEM_RDY high in the first cycle: no stall.
- Timeout and reset mid-wait:
  - MEM_RDY held 0 with WAIT_LIMIT=15: CSAI=0x3F0 and ERR=1.
  - RST_N pulsed low mid-wait: all outputs return to reset values immediately.
